// File: rtl/id_imm_sequencer.sv
// Decode-stage front end: two-entry skid buffer between IF and the immediate generator,
// with opcode-to-immediate-format decode, illegal flagging and a saturating illegal count.
module id_imm_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc,
    output logic             if_ready,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [2:0]       id_imm_select,
    output logic [24:0]      id_imm_inst,
    output logic [6:0]       id_opcode,
    output logic [31:0]      id_pc,
    output logic             id_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef struct packed {
        logic [2:0]  sel;
        logic [24:0] imm_inst;
        logic [6:0]  opcode;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

    state_e             state_q, state_d;
    entry_t             main_q, main_d;
    entry_t             skid_q, skid_d;
    entry_t             in_entry;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               handoff;

    always_comb begin
        in_entry.sel      = 3'd0;
        in_entry.imm_inst = if_inst[31:7];
        in_entry.opcode   = if_inst[6:0];
        in_entry.pc       = if_pc;
        in_entry.illegal  = 1'b0;
        if (if_inst[1:0] != 2'b11) begin
            in_entry.illegal = 1'b1;
        end else begin
            case (if_inst[6:0])
                7'b0010011, 7'b0000011, 7'b1100111,
                7'b1110011, 7'b0001111, 7'b0110011: in_entry.sel = 3'd0;
                7'b0100011:                         in_entry.sel = 3'd1;
                7'b0110111, 7'b0010111:             in_entry.sel = 3'd2;
                7'b1100011:                         in_entry.sel = 3'd3;
                7'b1101111:                         in_entry.sel = 3'd4;
                default:                            in_entry.illegal = 1'b1;
            endcase
        end
    end

    // Ready depends only on registered state and reset, never on ex_ready.
    assign if_ready = (state_q != StSkid) && !rst;
    assign id_valid = (state_q != StEmpty);
    assign accept   = if_valid && if_ready;
    assign handoff  = id_valid && ex_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StFull;
                        main_d  = in_entry;
                    end
                end
                StFull: begin
                    if (accept && handoff) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        state_d = StSkid;
                        skid_d  = in_entry;
                    end else if (handoff) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    if (handoff) begin
                        state_d = StFull;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        if (handoff && main_q.illegal && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            cnt_q   <= cnt_d;
        end
    end

    // Skid contents are only meaningful in StSkid, so no reset is needed.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign id_imm_select = main_q.sel;
    assign id_imm_inst   = main_q.imm_inst;
    assign id_opcode     = main_q.opcode;
    assign id_pc         = main_q.pc;
    assign id_illegal    = main_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_id_imm_sequencer.sv
// Self-checking bench for id_imm_sequencer: directed scenarios plus a randomized run
// against a queue-based reference model; a second instance uses a 2-bit counter.
module tb_id_imm_sequencer;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_ready;

    logic        if_ready,  if_ready2;
    logic        id_valid,  id_valid2;
    logic [2:0]  id_imm_select, id_imm_select2;
    logic [24:0] id_imm_inst, id_imm_inst2;
    logic [6:0]  id_opcode, id_opcode2;
    logic [31:0] id_pc, id_pc2;
    logic        id_illegal, id_illegal2;
    logic [7:0]  illegal_count;
    logic [1:0]  illegal_count2;

    id_imm_sequencer dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_ready(if_ready), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
        .id_imm_select(id_imm_select), .id_imm_inst(id_imm_inst), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_illegal(id_illegal), .illegal_count(illegal_count)
    );

    id_imm_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_ready(if_ready2), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid2),
        .id_imm_select(id_imm_select2), .id_imm_inst(id_imm_inst2), .id_opcode(id_opcode2),
        .id_pc(id_pc2), .id_illegal(id_illegal2), .illegal_count(illegal_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    item_t       mq[$];
    int unsigned mcnt;
    logic [31:0] hand_pcs[$];

    logic [6:0] legal_ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h33,
                                   7'h23, 7'h37, 7'h17, 7'h63, 7'h6F};

    // Returns {illegal, select} from the opcode classes.
    function automatic logic [3:0] ref_decode(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        if (inst[1:0] != 2'b11) return 4'b1000;
        if (op == 7'h23) return 4'd1;
        if (op == 7'h37 || op == 7'h17) return 4'd2;
        if (op == 7'h63) return 4'd3;
        if (op == 7'h6F) return 4'd4;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 ||
            op == 7'h0F || op == 7'h33) return 4'd0;
        return 4'b1000;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock: evaluate the model on the current inputs, then step past the edge.
    task automatic tick();
        bit          acc;
        bit          hnd;
        logic [3:0]  d;
        acc = !rst && if_valid && (mq.size() < 2);
        hnd = !rst && (mq.size() > 0) && ex_ready;
        if (hnd) hand_pcs.push_back(id_pc);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (hnd) begin
                d = ref_decode(mq[0].inst);
                if (d[3]) mcnt++;
                void'(mq.pop_front());
            end
            if (acc) mq.push_back('{inst: if_inst, pc: if_pc});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b0;
        tick();
        tick();
        checks += 8;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got=%b want=0", if_ready); end
        if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got=%b want=0", id_valid); end
        if (id_imm_select !== 3'd0) begin errors++; $display("FAIL reset_select got=%0d want=0", id_imm_select); end
        if (id_imm_inst !== 25'd0) begin errors++; $display("FAIL reset_imm_inst got=%h want=0", id_imm_inst); end
        if (id_opcode !== 7'd0) begin errors++; $display("FAIL reset_opcode got=%h want=0", id_opcode); end
        if (id_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h want=0", id_pc); end
        if (id_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", id_illegal); end
        if (illegal_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", illegal_count); end
        rst = 1'b0;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL post_reset_if_ready got=%b want=1", if_ready); end
    endtask

    task automatic test_format_decode();
        logic [31:0] insts [5] = '{32'h00500093, 32'h00112623, 32'h123450B7,
                                   32'hFE000EE3, 32'h0080006F};
        ex_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_valid = 1'b1; if_inst = insts[i]; if_pc = 32'h1000 + 32'(4 * i);
            tick();
            checks += 4;
            if (id_valid !== 1'b1) begin errors++; $display("FAIL fmt_valid[%0d] got=%b want=1", i, id_valid); end
            if (id_imm_select !== 3'(i)) begin errors++; $display("FAIL fmt_select[%0d] got=%0d want=%0d", i, id_imm_select, i); end
            if (id_pc !== 32'h1000 + 32'(4 * i)) begin errors++; $display("FAIL fmt_pc[%0d] got=%h want=%h", i, id_pc, 32'h1000 + 32'(4 * i)); end
            if (id_illegal !== 1'b0) begin errors++; $display("FAIL fmt_illegal[%0d] got=%b want=0", i, id_illegal); end
            if (i == 0) begin
                checks++;
                if (id_imm_inst !== 25'h000A001) begin errors++; $display("FAIL fmt_imm_inst got=%h want=000a001", id_imm_inst); end
            end
        end
        if_valid = 1'b0;
        tick();
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL fmt_drain got=%b want=0", id_valid); end
    endtask

    task automatic test_illegal();
        ex_ready = 1'b1;
        if_valid = 1'b1; if_inst = 32'hFFFFFFFF; if_pc = 32'h2000;
        tick();
        checks += 3;
        if (id_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag0 got=%b want=1", id_illegal); end
        if (id_imm_select !== 3'd0) begin errors++; $display("FAIL ill_sel0 got=%0d want=0", id_imm_select); end
        if (illegal_count !== 8'd0) begin errors++; $display("FAIL ill_cnt0 got=%0d want=0", illegal_count); end
        if_inst = 32'h00000001; if_pc = 32'h2004;
        tick();
        checks += 3;
        if (id_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag1 got=%b want=1", id_illegal); end
        if (id_imm_select !== 3'd0) begin errors++; $display("FAIL ill_sel1 got=%0d want=0", id_imm_select); end
        if (illegal_count !== 8'd1) begin errors++; $display("FAIL ill_cnt1 got=%0d want=1", illegal_count); end
        if_valid = 1'b0;
        tick();
        checks += 2;
        if (illegal_count !== 8'd2) begin errors++; $display("FAIL ill_cnt2 got=%0d want=2", illegal_count); end
        if (id_valid !== 1'b0) begin errors++; $display("FAIL ill_drain got=%b want=0", id_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pcs [3] = '{32'hA0, 32'hB0, 32'hC0};
        logic [31:0] exp_pc [6] = '{32'hA0, 32'hA0, 32'hA0, 32'hB0, 32'hC0, 32'h0};
        logic        exp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int          src;
        hand_pcs.delete();
        src = 0;
        for (int c = 0; c < 6; c++) begin
            ex_ready = (c >= 3);
            if_valid = (src < 3);
            if (src < 3) begin if_inst = 32'h00000013 | (32'(src) << 20); if_pc = pcs[src]; end
            if (if_valid && if_ready) src++;
            tick();
            checks++;
            if (if_ready !== exp_rdy[c]) begin errors++; $display("FAIL bp_ready[%0d] got=%b want=%b", c, if_ready, exp_rdy[c]); end
            if (c < 5) begin
                checks++;
                if (id_pc !== exp_pc[c]) begin errors++; $display("FAIL bp_pc[%0d] got=%h want=%h", c, id_pc, exp_pc[c]); end
            end
        end
        checks += 2;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b want=0", id_valid); end
        if (hand_pcs.size() != 3) begin
            errors++; $display("FAIL bp_handoff_count got=%0d want=3", hand_pcs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hand_pcs[i] !== pcs[i]) begin errors++; $display("FAIL bp_order[%0d] got=%h want=%h", i, hand_pcs[i], pcs[i]); end
            end
        end
        if_valid = 1'b0;
    endtask

    task automatic test_flush();
        int unsigned cnt_before;
        cnt_before = illegal_count;
        ex_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'hFFFFFFFF; if_pc = 32'h3000;
        tick();
        if_inst = 32'h00000013; if_pc = 32'h3004;
        tick();
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL fl_skid_ready got=%b want=0", if_ready); end
        flush = 1'b1; ex_ready = 1'b1; if_inst = 32'h00000037; if_pc = 32'h3008;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        checks += 3;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got=%b want=0", id_valid); end
        if (if_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got=%b want=1", if_ready); end
        if (illegal_count !== 8'(cnt_before)) begin errors++; $display("FAIL fl_count got=%0d want=%0d", illegal_count, cnt_before); end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_discard got=%b want=0", id_valid); end
        // Flush in FULL with a same-cycle accept.
        if_valid = 1'b1; if_inst = 32'h00000013; if_pc = 32'h3010;
        tick();
        flush = 1'b1; if_pc = 32'h3014;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_full_accept got=%b want=0", id_valid); end
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if_valid = (k < 5); if_inst = 32'hFFFFFF7F; if_pc = 32'h4000 + 32'(k);
            tick();
            if (k >= 1) begin
                checks += 2;
                if (illegal_count2 !== exp2[k-1]) begin errors++; $display("FAIL sat_cnt2[%0d] got=%0d want=%0d", k, illegal_count2, exp2[k-1]); end
                if (illegal_count !== 8'(k)) begin errors++; $display("FAIL sat_cnt8[%0d] got=%0d want=%0d", k, illegal_count, k); end
            end
        end
        if_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        ex_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'hFFFFFFFF; if_pc = 32'h5000;
        tick();
        if_inst = 32'h0000006F; if_pc = 32'h5004;
        tick();
        if_valid = 1'b0; rst = 1'b1;
        tick();
        checks += 5;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL rm_ready got=%b want=0", if_ready); end
        if (id_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b want=0", id_valid); end
        if ({id_imm_select, id_imm_inst, id_opcode, id_pc, id_illegal} !== 68'd0) begin
            errors++; $display("FAIL rm_data got=%h want=0", {id_imm_select, id_imm_inst, id_opcode, id_pc, id_illegal});
        end
        if (illegal_count !== 8'd0) begin errors++; $display("FAIL rm_count got=%0d want=0", illegal_count); end
        if (illegal_count2 !== 2'd0) begin errors++; $display("FAIL rm_count2 got=%0d want=0", illegal_count2); end
        rst = 1'b0; ex_ready = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after got=%b want=1", if_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (id_valid !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d] got=%b want=0", i, id_valid); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  d;
        logic [31:0] r;
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            r        = $urandom();
            if ($urandom_range(0, 4) != 0) if_inst = {r[31:7], legal_ops[$urandom_range(0, 10)]};
            else                           if_inst = r;
            if_pc    = $urandom();
            tick();
            checks += 4;
            if (if_ready !== (!rst && mq.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, if_ready, !rst && mq.size() < 2); end
            if (id_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got=%b want=%b", c, id_valid, mq.size() > 0); end
            if (illegal_count !== 8'(sat(mcnt, 255))) begin errors++; $display("FAIL rnd_cnt[%0d] got=%0d want=%0d", c, illegal_count, sat(mcnt, 255)); end
            if (illegal_count2 !== 2'(sat(mcnt, 3))) begin errors++; $display("FAIL rnd_cnt2[%0d] got=%0d want=%0d", c, illegal_count2, sat(mcnt, 3)); end
            if (mq.size() > 0) begin
                d = ref_decode(mq[0].inst);
                checks++;
                if ({id_imm_select, id_imm_inst, id_opcode, id_pc, id_illegal} !==
                    {d[2:0], mq[0].inst[31:7], mq[0].inst[6:0], mq[0].pc, d[3]}) begin
                    errors++;
                    $display("FAIL rnd_bundle[%0d] got=%h want=%h", c,
                             {id_imm_select, id_imm_inst, id_opcode, id_pc, id_illegal},
                             {d[2:0], mq[0].inst[31:7], mq[0].inst[6:0], mq[0].pc, d[3]});
                end
            end
        end
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
    endtask

    initial begin
        mcnt = 0;
        test_reset();
        test_format_decode();
        test_illegal();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_imm_sequencer.md
# id_imm_sequencer

Decode-stage front end that sits between the IF/ID boundary and the immediate generator. It holds the instruction and PC in a two-entry skid buffer with valid/ready handshakes on both sides. It decodes the opcode into the 3-bit immediate-format select (I=0, S=1, U=2, B=3, J=4) and presents registered `inst[31:7]` plus the select to the immediate generator. It also flags illegal opcodes, honours pipeline flushes, and keeps a saturating illegal-instruction count.

## Interface
- `CNT_W`, default 8: width of `illegal_count`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_valid`  in  1  IF presents an instruction.
- `if_inst`  in  32  full 32-bit (already expanded) instruction.
- `if_pc`  in  32  PC of `if_inst`.
- `if_ready`  out  1  ID can accept this cycle.
- `flush`  in  1  discard all held and incoming instructions.
- `ex_ready`  in  1  downstream accepts the `id_*` bundle.
- `id_valid`  out  1  `id_*` outputs hold a valid instruction.
- `id_imm_select`  out  3  immediate-format select for the immediate generator.
- `id_imm_inst`  out  25  `inst[31:7]` for the immediate generator.
- `id_opcode`  out  7  `inst[6:0]`.
- `id_pc`  out  32  PC of the presented instruction.
- `id_illegal`  out  1  presented instruction is illegal.
- `illegal_count`  out  `CNT_W`  saturating count of illegal instructions handed to EX.

## Operation
- **Decode (combinational on `if_inst`, registered on accept):**
  - Opcodes 0010011, 0000011, 1100111, 1110011, 0001111, 0110011 give select 0. For R-type (0110011) the select is a don't-care, driven as 0.
  - Opcode 0100011 gives select 1.
  - Opcodes 0110111 and 0010111 give select 2.
  - Opcode 1100011 gives select 3.
  - Opcode 1101111 gives select 4.
  - Any other opcode, or `inst[1:0]` ≠ 2'b11, gives `illegal`=1 and select 0.
- **Entries:** main (drives the `id_*` outputs) and skid. Each entry holds {select, inst[31:7], opcode, pc, illegal}.
- **Handshake events:**
  - accept = `if_valid & if_ready`.
  - handoff = `id_valid & ex_ready`.
- **`if_ready`:** 1 when the state is not SKID and `rst`=0. Forced 0 while `rst`=1.
- **States:** EMPTY (`id_valid`=0), FULL (main valid), SKID (main and skid valid).
- **EMPTY:** accept → FULL, main ← input.
- **FULL:**
  - accept & handoff → FULL, main ← input.
  - accept & !handoff → SKID, skid ← input.
  - !accept & handoff → EMPTY.
  - Otherwise hold.
- **SKID:** handoff → FULL, main ← skid. Otherwise hold; all entry contents stable.
- **Flush:** highest priority.
  - Next state EMPTY from any state.
  - A same-cycle accept is discarded, though `if_ready` is still driven normally.
  - `illegal_count` is not incremented in a flush cycle.
- **Counter:** increments on handoff & `id_illegal` & !`flush`. It saturates at all-ones and is cleared only by `rst`.
- **Stable outputs:** while `id_valid`=1 and `ex_ready`=0, every `id_*` output is held stable.
- **Entry data during reset/flush:** need not be cleared, but `id_*` data outputs are 0 after reset.

## Timing
- **Reset values:**
  - `id_valid`=0, `id_imm_select`=0, `id_imm_inst`=0, `id_opcode`=0, `id_pc`=0, `id_illegal`=0, `illegal_count`=0.
  - `if_ready`=0 during reset and 1 on the first cycle after `rst` deasserts.
- **Latency:** an instruction accepted at edge N is visible on `id_*` with `id_valid`=1 after edge N.
- **Throughput:** 1 instruction per cycle while `ex_ready`=1.
- **Backpressure:** one `ex_ready` low cycle with `if_valid` high fills the skid. `if_ready` then drops the following cycle; it is registered-state-derived, with no combinational path from `ex_ready`.
- **Recovery:** after SKID → FULL, `if_ready` returns to 1 on the next cycle.
- **Ordering:** strict FIFO, with no loss or duplication absent flush.
- **Reset mid-operation:** discards both entries. The counter clears on the same edge.

## Test plan
- **Format decode:** reset, `ex_ready`=1, stream 0x00500093, 0x00112623, 0x123450B7, 0xFE000EE3, 0x0080006F.
  - Required `id_imm_select` sequence: 0, 1, 2, 3, 4 on consecutive cycles.
  - First `id_imm_inst` = 25'h000A001; `id_pc` tracks the input.
- **Illegal flagging:** send 0xFFFFFFFF and 0x00000001 back-to-back → `id_illegal`=1 for both, select 0, `illegal_count` 0 → 1 → 2.
- **Backpressure/skid:** `ex_ready`=0 for 3 cycles while feeding A, B, C continuously.
  - A is held on `id_*` and B lands in the skid.
  - `if_ready`=0 until `ex_ready` rises.
  - C is accepted after the restart; EX sees A, B, C in order exactly once.
- **Flush priority:** in the SKID state assert `flush` together with `if_valid`.
  - Next cycle `id_valid`=0 and state EMPTY.
  - The flushed illegal instruction in main does not increment `illegal_count`.
- **Counter saturation:** with `CNT_W`=2, hand off 5 illegal instructions → count reads 1, 2, 3, 3, 3.
- **Reset mid-operation:** assert `rst` for 1 cycle while in SKID.
  - All outputs go to their reset values.
  - `if_ready`=0 during reset and 1 after.
  - No pre-reset instruction appears afterwards.
